// File: rtl/video_capture_if.sv
// Signal bundle between a Vdp video source, the capture block and its framebuffer write port.
// The slave modport is the capture block's view; master is the source/sink side.
interface video_capture_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  enable;
    logic                  hSync;
    logic                  vSync;
    logic [7:0]            rgb;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [7:0]            wrData;
    logic                  wrEn;
    logic                  busy;
    logic                  frameDone;
    logic                  shortFrame;
    logic [15:0]           frameCrc;

    modport slave (
        input  enable,
        input  hSync,
        input  vSync,
        input  rgb,
        output wrAddr,
        output wrData,
        output wrEn,
        output busy,
        output frameDone,
        output shortFrame,
        output frameCrc
    );

    modport master (
        output enable,
        output hSync,
        output vSync,
        output rgb,
        input  wrAddr,
        input  wrData,
        input  wrEn,
        input  busy,
        input  frameDone,
        input  shortFrame,
        input  frameCrc
    );
endinterface

// File: rtl/video_capture.sv
// Vdp video receiver: recovers pixel/line position from sync edges and writes the active window
// into a linear framebuffer. Define CAPTURE_CRC_EN to add a per-frame CRC-16/CCITT-FALSE.
module video_capture #(
    parameter int H_BACK     = 16,
    parameter int H_ACTIVE   = 256,
    parameter int V_BACK     = 16,
    parameter int V_ACTIVE   = 240,
    parameter int ADDR_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    video_capture_if.slave   bus
);
    // Counters get one spare bit so saturation lands well outside the active window.
    localparam int H_W = $clog2(H_BACK + H_ACTIVE + 1) + 1;
    localparam int V_W = $clog2(V_BACK + V_ACTIVE + 1) + 1;
    localparam logic [H_W-1:0] H_LO = H_W'(H_BACK);
    localparam logic [H_W-1:0] H_HI = H_W'(H_BACK + H_ACTIVE);
    localparam logic [V_W-1:0] V_LO = V_W'(V_BACK);
    localparam logic [V_W-1:0] V_HI = V_W'(V_BACK + V_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VSYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                  hs_r1_q, vs_r1_q, hs_r2_q, vs_r2_q;
    logic [7:0]            rgb_r1_q;
    logic                  h_fall, v_fall;
    logic [H_W-1:0]        h_cnt_q, h_cnt_d;
    logic [V_W-1:0]        v_line_q, v_line_d;
    logic                  active;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  short_q, short_d;
    logic                  busy_q;
    logic                  frame_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_r1_q  <= 1'b0;
            vs_r1_q  <= 1'b0;
            hs_r2_q  <= 1'b0;
            vs_r2_q  <= 1'b0;
            rgb_r1_q <= '0;
        end else begin
            hs_r1_q  <= bus.hSync;
            vs_r1_q  <= bus.vSync;
            hs_r2_q  <= hs_r1_q;
            vs_r2_q  <= vs_r1_q;
            rgb_r1_q <= bus.rgb;
        end
    end

    assign h_fall = hs_r2_q & ~hs_r1_q;
    assign v_fall = vs_r2_q & ~vs_r1_q;

    // Position of the pixel currently held in the first input register.
    always_comb begin
        h_cnt_d = h_cnt_q;
        if (h_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != '1) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    always_comb begin
        v_line_d = v_line_q;
        if (v_fall) begin
            v_line_d = '0;
        end else if (h_fall && (v_line_q != '1)) begin
            v_line_d = v_line_q + 1'b1;
        end
    end

    assign active = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                    (v_line_d >= V_LO) && (v_line_d < V_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        short_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_WAIT_VSYNC;
                end
            end
            S_WAIT_VSYNC: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (v_fall) begin
                    state_d = S_CAPTURE;
                    idx_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (v_fall) begin
                    short_d = 1'b1;
                    idx_d   = '0;
                end else if (active) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = rgb_r1_q;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = bus.enable ? S_WAIT_VSYNC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered off the FSM state, so they trail it by one cycle
    // and line up with the write port: frameDone follows the last write by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q      <= '0;
            v_line_q     <= '0;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            short_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_line_q     <= v_line_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            short_q      <= short_d;
            busy_q       <= (state_q == S_WAIT_VSYNC) || (state_q == S_CAPTURE);
            frame_done_q <= (state_q == S_DONE);
        end
    end

    assign bus.wrEn       = wr_en_q;
    assign bus.wrAddr     = wr_addr_q;
    assign bus.wrData     = wr_data_q;
    assign bus.shortFrame = short_q;
    assign bus.busy       = busy_q;
    assign bus.frameDone  = frame_done_q;

`ifdef CAPTURE_CRC_EN
    logic [15:0] crc_run_q;
    logic [15:0] frame_crc_q;
    logic [15:0] crc_chain [0:8];
    logic        crc_clr;

    assign crc_clr      = short_d || ((state_q == S_WAIT_VSYNC) && (state_d == S_CAPTURE));
    assign crc_chain[0] = crc_run_q;

    // One byte per cycle, unrolled MSB-first over poly 0x1021.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_crc_bit
            logic fb;
            assign fb             = crc_chain[gi][15] ^ rgb_r1_q[7-gi];
            assign crc_chain[gi+1] = {crc_chain[gi][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run_q   <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            if (crc_clr) begin
                crc_run_q <= 16'hFFFF;
            end else if (wr_en_d) begin
                crc_run_q <= crc_chain[8];
            end
            if (state_q == S_DONE) begin
                frame_crc_q <= crc_run_q;
            end
        end
    end

    assign bus.frameCrc = frame_crc_q;
`else
    assign bus.frameCrc = 16'h0000;
`endif
endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture: stimulus tasks queue the expected writes and pulses,
// a negedge monitor pops and compares them against what the two DUT instances present.
module tb_video_capture;
    localparam int AW = 16;

`ifdef CAPTURE_CRC_EN
    localparam logic [15:0] EXP_CRC2 = 16'h29B1;
`else
    localparam logic [15:0] EXP_CRC2 = 16'h0000;
`endif

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_capture_if #(.ADDR_WIDTH(AW)) vif ();
    video_capture_if #(.ADDR_WIDTH(AW)) vif2 ();

    video_capture #(
        .H_BACK(2), .H_ACTIVE(4), .V_BACK(1), .V_ACTIVE(2), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .bus(vif.slave)
    );

    video_capture #(
        .H_BACK(2), .H_ACTIVE(9), .V_BACK(1), .V_ACTIVE(1), .ADDR_WIDTH(AW)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(vif2.slave)
    );

    wr_t exp_q[$];
    wr_t exp2_q[$];
    int  done_q[$];
    int  done2_q[$];
    int  short_q[$];
    int  n_vec = 0;
    int  n_miss = 0;
    bit  chk_busy = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name, input int at);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event required at cycle %0d, seen at cycle %0d", name, at, cyc);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_t e;
        int  d;
        if (chk_busy)
            check("busy", {31'd0, vif.busy}, (done_q.size() > 0 && done_q[0] == cyc) ? 32'd0 : 32'd1);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            flag("missing_write", e.cyc);
        end
        while (done_q.size() > 0 && done_q[0] < cyc) flag("missing_frameDone", done_q.pop_front());
        while (short_q.size() > 0 && short_q[0] < cyc) flag("missing_shortFrame", short_q.pop_front());
        while (exp2_q.size() > 0 && exp2_q[0].cyc < cyc) begin
            e = exp2_q.pop_front();
            flag("missing_write2", e.cyc);
        end
        while (done2_q.size() > 0 && done2_q[0] < cyc) flag("missing_frameDone2", done2_q.pop_front());

        if (vif.wrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_write", -1);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", {16'd0, vif.wrAddr}, e.addr);
                check("wr_data", {24'd0, vif.wrData}, e.data);
                $display("dut  write addr=%0d data=%02h cycle=%0d", vif.wrAddr, vif.wrData, cyc);
            end
        end
        if (vif.frameDone === 1'b1) begin
            if (done_q.size() == 0) flag("unexpected_frameDone", -1);
            else begin
                d = done_q.pop_front();
                check("frameDone_cycle", cyc, d);
                $display("dut  frameDone cycle=%0d crc=%04h", cyc, vif.frameCrc);
            end
        end
        if (vif.shortFrame === 1'b1) begin
            if (short_q.size() == 0) flag("unexpected_shortFrame", -1);
            else begin
                d = short_q.pop_front();
                check("shortFrame_cycle", cyc, d);
                $display("dut  shortFrame cycle=%0d", cyc);
            end
        end
        if (vif2.wrEn === 1'b1) begin
            if (exp2_q.size() == 0) flag("unexpected_write2", -1);
            else begin
                e = exp2_q.pop_front();
                check("wr2_cycle", cyc, e.cyc);
                check("wr2_addr", {16'd0, vif2.wrAddr}, e.addr);
                check("wr2_data", {24'd0, vif2.wrData}, e.data);
                $display("dut2 write addr=%0d data=%02h cycle=%0d", vif2.wrAddr, vif2.wrData, cyc);
            end
        end
        if (vif2.frameDone === 1'b1) begin
            if (done2_q.size() == 0) flag("unexpected_frameDone2", -1);
            else begin
                d = done2_q.pop_front();
                check("frameDone2_cycle", cyc, d);
                check("frameCrc2", {16'd0, vif2.frameCrc}, {16'd0, EXP_CRC2});
                $display("dut2 frameDone cycle=%0d crc=%04h", cyc, vif2.frameCrc);
            end
        end
    end

    // One 10-cycle line for dut: hSync high c=0..1, active pixels at c=4..7.
    // vSync is changed only at c=2 (with the hSync fall) and at c=8 (in blanking).
    task automatic line(input bit vs2, input bit vs8, input int row, input logic [7:0] base,
                        input bit cap, input bit exp_short, input bit rst_end);
        wr_t w;
        int  p;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            vif.hSync = (c < 2);
            if (c == 2) vif.vSync = vs2;
            if (c == 8) vif.vSync = vs8;
            if (row >= 0 && c >= 4 && c < 8) begin
                p = row * 4 + c - 4;
                vif.rgb = base + 8'(p);
                if (cap) begin
                    w.cyc  = cyc + 2;
                    w.addr = p;
                    w.data = int'(base) + p;
                    exp_q.push_back(w);
                    if (p == 7) done_q.push_back(cyc + 3);
                end
            end else begin
                vif.rgb = 8'hA0 + 8'(c);
            end
            if (exp_short && c == 2) short_q.push_back(cyc + 2);
            if (rst_end && c == 9) reset = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] base, input bit cap);
        line(1, 1, -1, base, cap, 0, 0);
        line(0, 0, -1, base, cap, 0, 0);
        line(0, 0,  0, base, cap, 0, 0);
        line(0, 0,  1, base, cap, 0, 0);
        line(0, 0, -1, base, cap, 0, 0);
    endtask

    // One 14-cycle line for dut2: active pixels at c=4..12 carry "123456789".
    task automatic line2(input bit vs2, input bit act);
        wr_t w;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            vif2.hSync = (c < 2);
            if (c == 2) vif2.vSync = vs2;
            if (act && c >= 4 && c < 13) begin
                vif2.rgb = 8'h31 + 8'(c - 4);
                w.cyc  = cyc + 2;
                w.addr = c - 4;
                w.data = 32'h31 + c - 4;
                exp2_q.push_back(w);
                if (c == 12) done2_q.push_back(cyc + 3);
            end else begin
                vif2.rgb = 8'h00;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vif.enable  = 1'b0; vif.hSync  = 1'b0; vif.vSync  = 1'b0; vif.rgb  = 8'h00;
        vif2.enable = 1'b0; vif2.hSync = 1'b0; vif2.vSync = 1'b0; vif2.rgb = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("por_wrEn", {31'd0, vif.wrEn}, 0);
        check("por_busy", {31'd0, vif.busy}, 0);
        check("por_wrAddr", {16'd0, vif.wrAddr}, 0);
        check("por_frameCrc2", {16'd0, vif2.frameCrc}, 0);

        // Full frames back to back with enable held; busy drops only with frameDone.
        vif.enable = 1'b1;
        line(0, 0, -1, 8'h00, 0, 0, 0);
        chk_busy = 1'b1;
        frame(8'h10, 1);
        frame(8'h40, 1);

        // vSync pulse after the first active line: short frame, then a clean restart.
        line(1, 1, -1, 8'h80, 1, 0, 0);
        line(0, 0, -1, 8'h80, 1, 0, 0);
        line(0, 1,  0, 8'h80, 1, 0, 0);
        line(0, 0, -1, 8'h90, 1, 1, 0);
        line(0, 0,  0, 8'h90, 1, 0, 0);
        line(0, 0,  1, 8'h90, 1, 0, 0);
        line(0, 0, -1, 8'h90, 1, 0, 0);
        chk_busy = 1'b0;

        // Reset held 3 cycles mid-stream, then a whole frame with enable low.
        line(0, 0, -1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            vif.enable = 1'b0;
            vif.hSync = (i == 0);
        end
        @(negedge clk);
        check("rst_wrAddr", {16'd0, vif.wrAddr}, 0);
        check("rst_wrData", {24'd0, vif.wrData}, 0);
        check("rst_wrEn", {31'd0, vif.wrEn}, 0);
        check("rst_busy", {31'd0, vif.busy}, 0);
        check("rst_frameDone", {31'd0, vif.frameDone}, 0);
        check("rst_shortFrame", {31'd0, vif.shortFrame}, 0);
        check("rst_frameCrc", {16'd0, vif.frameCrc}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        frame(8'h20, 0);

        // Reset while wrAddr=3 is on the port: writes stop at once, block idles.
        vif.enable = 1'b1;
        line(0, 0, -1, 8'h00, 0, 0, 0);
        line(1, 1, -1, 8'hC0, 1, 0, 0);
        line(0, 0, -1, 8'hC0, 1, 0, 0);
        line(0, 0,  0, 8'hC0, 1, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        vif.hSync = 1'b1;
        @(negedge clk);
        check("abort_wrEn", {31'd0, vif.wrEn}, 0);
        check("abort_busy", {31'd0, vif.busy}, 0);
        line(0, 0,  1, 8'hC0, 0, 0, 0);
        line(0, 0, -1, 8'hC0, 0, 0, 0);
        vif.enable = 1'b0;

        // Nine-pixel single-line frame for the CRC check value.
        vif2.enable = 1'b1;
        line2(0, 0);
        line2(1, 0);
        line2(0, 0);
        line2(0, 1);
        line2(0, 0);
        vif2.enable = 1'b0;
        line2(0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        check("pending_frameDone", done_q.size(), 0);
        check("pending_shortFrame", short_q.size(), 0);
        check("pending_writes2", exp2_q.size(), 0);
        check("pending_frameDone2", done2_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
